// File: rtl/fc_chain_sched.sv
// Sequencer for a two-layer fully-connected chain. It loads host words into
// layer 1's input buffer, runs layer 1, copies layer 1's function output into
// layer 2's input buffer, runs layer 2, and streams layer 2's function output
// back to the host. All outputs come straight from registers.
module fc_chain_sched #(
    parameter int input_size_1         = 784,
    parameter int output_size_1        = 784,
    parameter int input_size_2         = 784,
    parameter int output_size_2        = 1500,
    parameter int datatype_size        = 8,
    parameter int output_datatype_size = datatype_size
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_in_valid,
    input  logic [datatype_size-1:0]            i_in_data,
    output logic                                o_in_ready,
    output logic                                o_out_valid,
    output logic [output_datatype_size-1:0]     o_out_data,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_ibuf_we_1,
    output logic [datatype_size-1:0]            o_ibuf_wr_data_1,
    output logic [$clog2(input_size_1)-1:0]     o_ibuf_addr_1,
    output logic                                o_start_1,
    input  logic                                i_busy_1,
    output logic                                o_func_start_1,
    input  logic                                i_func_valid_1,
    input  logic [output_datatype_size-1:0]     i_func_data_1,
    output logic                                o_ibuf_we_2,
    output logic [datatype_size-1:0]            o_ibuf_wr_data_2,
    output logic [$clog2(input_size_2)-1:0]     o_ibuf_addr_2,
    output logic                                o_start_2,
    input  logic                                i_busy_2,
    output logic                                o_func_start_2,
    input  logic                                i_func_valid_2,
    input  logic [output_datatype_size-1:0]     i_func_data_2
);

    localparam int A1_W  = $clog2(input_size_1);
    localparam int A2_W  = $clog2(input_size_2);
    localparam int MAX_A = (input_size_1 > output_size_1) ? input_size_1 : output_size_1;
    localparam int MAX_N = (MAX_A > output_size_2) ? MAX_A : output_size_2;
    // One shared word counter, wide enough for the longest of the three streams
    localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [CNT_W-1:0] LAST_IN1  = CNT_W'(input_size_1 - 1);
    localparam logic [CNT_W-1:0] LAST_OUT1 = CNT_W'(output_size_1 - 1);
    localparam logic [CNT_W-1:0] LAST_OUT2 = CNT_W'(output_size_2 - 1);

    // Layer 1's output feeds layer 2's input buffer word for word, and the
    // function output lands in an activation-wide buffer.
    generate
        if (output_size_1 != input_size_2) begin : g_chk_chain
            $error("fc_chain_sched: output_size_1 must equal input_size_2");
        end
        if (output_datatype_size != datatype_size) begin : g_chk_width
            $error("fc_chain_sched: output_datatype_size must equal datatype_size");
        end
    endgenerate

    typedef enum logic [3:0] {
        LOAD1, GAP1, START1, WAIT1, FUNC1, GAP2, START2, WAIT2, FUNC2
    } state_t;

    state_t                            r_state;
    logic [CNT_W-1:0]                  r_cnt;
    logic                              r_seen_busy;
    logic                              r_in_ready;
    logic                              r_out_valid;
    logic [output_datatype_size-1:0]   r_out_data;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_ibuf_we_1;
    logic [datatype_size-1:0]          r_ibuf_wr_data_1;
    logic [A1_W-1:0]                   r_ibuf_addr_1;
    logic                              r_start_1;
    logic                              r_func_start_1;
    logic                              r_ibuf_we_2;
    logic [datatype_size-1:0]          r_ibuf_wr_data_2;
    logic [A2_W-1:0]                   r_ibuf_addr_2;
    logic                              r_start_2;
    logic                              r_func_start_2;

    // Sequencer FSM: every output is set here so it leaves a flop. r_busy is
    // written with the value the next state/count will have, so it reads as
    // (state != LOAD1 || cnt != 0) in the same cycle as that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= LOAD1;
            r_cnt            <= '0;
            r_seen_busy      <= 1'b0;
            r_in_ready       <= 1'b0;
            r_out_valid      <= 1'b0;
            r_out_data       <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_ibuf_we_1      <= 1'b0;
            r_ibuf_wr_data_1 <= '0;
            r_ibuf_addr_1    <= '0;
            r_start_1        <= 1'b0;
            r_func_start_1   <= 1'b0;
            r_ibuf_we_2      <= 1'b0;
            r_ibuf_wr_data_2 <= '0;
            r_ibuf_addr_2    <= '0;
            r_start_2        <= 1'b0;
            r_func_start_2   <= 1'b0;
        end else begin
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_done         <= 1'b0;
            r_ibuf_we_1    <= 1'b0;
            r_start_1      <= 1'b0;
            r_func_start_1 <= 1'b0;
            r_ibuf_we_2    <= 1'b0;
            r_start_2      <= 1'b0;
            r_func_start_2 <= 1'b0;
            case (r_state)
                LOAD1: begin
                    r_in_ready <= 1'b1;
                    if (i_in_valid && r_in_ready) begin
                        r_ibuf_we_1      <= 1'b1;
                        r_ibuf_addr_1    <= r_cnt[A1_W-1:0];
                        r_ibuf_wr_data_1 <= i_in_data;
                        r_busy           <= 1'b1;
                        if (r_cnt == LAST_IN1) begin
                            r_cnt      <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= GAP1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                GAP1: begin
                    r_start_1 <= 1'b1;
                    r_state   <= START1;
                end
                START1: begin
                    r_seen_busy <= 1'b0;
                    r_state     <= WAIT1;
                end
                WAIT1: begin
                    if (i_busy_1) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_func_start_1 <= 1'b1;
                        r_state        <= FUNC1;
                    end
                end
                FUNC1: begin
                    if (i_func_valid_1) begin
                        r_ibuf_we_2      <= 1'b1;
                        r_ibuf_addr_2    <= r_cnt[A2_W-1:0];
                        r_ibuf_wr_data_2 <= i_func_data_1;
                        if (r_cnt == LAST_OUT1) begin
                            r_cnt   <= '0;
                            r_state <= GAP2;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                GAP2: begin
                    r_start_2 <= 1'b1;
                    r_state   <= START2;
                end
                START2: begin
                    r_seen_busy <= 1'b0;
                    r_state     <= WAIT2;
                end
                WAIT2: begin
                    if (i_busy_2) begin
                        r_seen_busy <= 1'b1;
                    end else if (r_seen_busy) begin
                        r_func_start_2 <= 1'b1;
                        r_state        <= FUNC2;
                    end
                end
                FUNC2: begin
                    if (i_func_valid_2) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= i_func_data_2;
                        if (r_cnt == LAST_OUT2) begin
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= LOAD1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= LOAD1;
                end
            endcase
        end
    end

    assign o_in_ready       = r_in_ready;
    assign o_out_valid      = r_out_valid;
    assign o_out_data       = r_out_data;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_ibuf_we_1      = r_ibuf_we_1;
    assign o_ibuf_wr_data_1 = r_ibuf_wr_data_1;
    assign o_ibuf_addr_1    = r_ibuf_addr_1;
    assign o_start_1        = r_start_1;
    assign o_func_start_1   = r_func_start_1;
    assign o_ibuf_we_2      = r_ibuf_we_2;
    assign o_ibuf_wr_data_2 = r_ibuf_wr_data_2;
    assign o_ibuf_addr_2    = r_ibuf_addr_2;
    assign o_start_2        = r_start_2;
    assign o_func_start_2   = r_func_start_2;

endmodule

// File: tb/tb_fc_chain_sched.sv
// Scoreboard bench for fc_chain_sched with a 4/3/3/2 chain. The stimulus
// process pushes expected writes, pulses, results and per-cycle probes into
// queues; the monitor pops and compares them on the falling clock edge.
module tb_fc_chain_sched;

    localparam int IN1  = 4;
    localparam int OUT1 = 3;
    localparam int IN2  = 3;
    localparam int OUT2 = 2;
    localparam int DW   = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_in_valid;
    logic [DW-1:0]           i_in_data;
    logic                    o_in_ready;
    logic                    o_out_valid;
    logic [DW-1:0]           o_out_data;
    logic                    o_busy;
    logic                    o_done;
    logic                    o_ibuf_we_1;
    logic [DW-1:0]           o_ibuf_wr_data_1;
    logic [$clog2(IN1)-1:0]  o_ibuf_addr_1;
    logic                    o_start_1;
    logic                    i_busy_1;
    logic                    o_func_start_1;
    logic                    i_func_valid_1;
    logic [DW-1:0]           i_func_data_1;
    logic                    o_ibuf_we_2;
    logic [DW-1:0]           o_ibuf_wr_data_2;
    logic [$clog2(IN2)-1:0]  o_ibuf_addr_2;
    logic                    o_start_2;
    logic                    i_busy_2;
    logic                    o_func_start_2;
    logic                    i_func_valid_2;
    logic [DW-1:0]           i_func_data_2;

    fc_chain_sched #(
        .input_size_1(IN1), .output_size_1(OUT1), .input_size_2(IN2),
        .output_size_2(OUT2), .datatype_size(DW), .output_datatype_size(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data),
        .o_busy(o_busy), .o_done(o_done),
        .o_ibuf_we_1(o_ibuf_we_1), .o_ibuf_wr_data_1(o_ibuf_wr_data_1),
        .o_ibuf_addr_1(o_ibuf_addr_1), .o_start_1(o_start_1), .i_busy_1(i_busy_1),
        .o_func_start_1(o_func_start_1), .i_func_valid_1(i_func_valid_1),
        .i_func_data_1(i_func_data_1),
        .o_ibuf_we_2(o_ibuf_we_2), .o_ibuf_wr_data_2(o_ibuf_wr_data_2),
        .o_ibuf_addr_2(o_ibuf_addr_2), .o_start_2(o_start_2), .i_busy_2(i_busy_2),
        .o_func_start_2(o_func_start_2), .i_func_valid_2(i_func_valid_2),
        .i_func_data_2(i_func_data_2)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int sig; int cyc; } pulse_t;
    typedef struct { int cyc; int sig; int val; } probe_t;
    typedef struct { int data; int done; } out_t;

    wr_t    q_w1[$];
    wr_t    q_w2[$];
    pulse_t q_p[$];
    probe_t q_pr[$];
    out_t   q_o[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    bit fin_req = 1'b0;
    bit fin_ack = 1'b0;
    string pname[4] = '{"start_1", "func_start_1", "start_2", "func_start_2"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        probe_t     p;
        wr_t        w;
        pulse_t     pp;
        out_t       o;
        logic [3:0] pulses;
        if (rst) begin
            chk("reset_outputs",
                {o_in_ready, o_out_valid, o_out_data, o_busy, o_done,
                 o_ibuf_we_1, o_ibuf_wr_data_1, o_ibuf_addr_1, o_start_1, o_func_start_1,
                 o_ibuf_we_2, o_ibuf_wr_data_2, o_ibuf_addr_2, o_start_2, o_func_start_2},
                64'd0);
        end else begin
            while (q_pr.size() > 0 && q_pr[0].cyc <= cyc) begin
                p = q_pr.pop_front();
                chk("probe_cycle", cyc, p.cyc);
                if (p.sig == 0) chk("in_ready", o_in_ready, p.val);
                else            chk("busy", o_busy, p.val);
            end
            if (o_ibuf_we_1) begin
                if (q_w1.size() == 0) unexpected("ibuf1_write");
                else begin
                    w = q_w1.pop_front();
                    chk("ibuf1_addr", o_ibuf_addr_1, w.addr);
                    chk("ibuf1_data", o_ibuf_wr_data_1, w.data);
                end
            end
            if (o_ibuf_we_2) begin
                if (q_w2.size() == 0) unexpected("ibuf2_write");
                else begin
                    w = q_w2.pop_front();
                    chk("ibuf2_addr", o_ibuf_addr_2, w.addr);
                    chk("ibuf2_data", o_ibuf_wr_data_2, w.data);
                end
            end
            pulses = {o_func_start_2, o_start_2, o_func_start_1, o_start_1};
            for (int s = 0; s < 4; s++) begin
                if (pulses[s]) begin
                    if (q_p.size() == 0) unexpected(pname[s]);
                    else begin
                        pp = q_p.pop_front();
                        chk({pname[s], "_kind"}, s, pp.sig);
                        chk({pname[s], "_cycle"}, cyc, pp.cyc);
                    end
                end
            end
            if (o_out_valid) begin
                if (q_o.size() == 0) unexpected("out_valid");
                else begin
                    o = q_o.pop_front();
                    chk("out_data", o_out_data, o.data);
                    chk("out_done", o_done, o.done);
                end
            end else if (o_done) begin
                unexpected("done_without_valid");
            end
            if (fin_req && !fin_ack) begin
                chk("left_ibuf1", q_w1.size(), 0);
                chk("left_ibuf2", q_w2.size(), 0);
                chk("left_pulses", q_p.size(), 0);
                chk("left_outputs", q_o.size(), 0);
                chk("left_probes", q_pr.size(), 0);
                fin_ack = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input int sig, input int val);
        probe_t p;
        p.cyc = cyc; p.sig = sig; p.val = val;
        q_pr.push_back(p);
    endtask

    task automatic push_pulse(input int sig, input int at);
        pulse_t p;
        p.sig = sig; p.cyc = at;
        q_p.push_back(p);
    endtask

    // Streams IN1 host words back-to-back; returns in the START1 cycle
    task automatic load1(input int base);
        wr_t w;
        int  last = 0;
        for (int i = 0; i < IN1; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'(base + i);
            probe(0, 1);
            w.addr = i; w.data = base + i;
            q_w1.push_back(w);
            last = cyc;
            tick();
        end
        i_in_valid = 1'b0;
        probe(0, 0);
        probe(1, 1);
        push_pulse(0, last + 2);
        tick();
    endtask

    // Busy low for pre_low cycles, high for high_len, then falls; returns in the FUNCx cycle
    task automatic wait_busy(input int layer, input int pre_low, input int high_len);
        repeat (pre_low) tick();
        if (layer == 1) i_busy_1 = 1'b1; else i_busy_2 = 1'b1;
        repeat (high_len) tick();
        if (layer == 1) i_busy_1 = 1'b0; else i_busy_2 = 1'b0;
        push_pulse(layer == 1 ? 1 : 3, cyc + 1);
        tick();
    endtask

    task automatic fword1(input int idx, input int data);
        wr_t w;
        i_func_valid_1 = 1'b1;
        i_func_data_1  = 8'(data);
        w.addr = idx; w.data = data;
        q_w2.push_back(w);
        tick();
        i_func_valid_1 = 1'b0;
    endtask

    task automatic fword2(input int data, input int done);
        out_t o;
        i_func_valid_2 = 1'b1;
        i_func_data_2  = 8'(data);
        o.data = data; o.done = done;
        q_o.push_back(o);
        tick();
        i_func_valid_2 = 1'b0;
    endtask

    task automatic full_run(input int base, input int pre_low, input bit spur,
                            input int a0, input int a1, input int a2,
                            input int b0, input int b1);
        int last;
        load1(base);
        wait_busy(1, pre_low, 5);
        fword1(0, a0);
        tick();
        if (spur) begin
            i_func_valid_2 = 1'b1;
            i_func_data_2  = 8'h33;
            tick();
            i_func_valid_2 = 1'b0;
        end
        fword1(1, a1);
        tick();
        last = cyc;
        fword1(2, a2);
        push_pulse(2, last + 2);
        tick();
        wait_busy(2, 0, 3);
        fword2(b0, 0);
        tick();
        fword2(b1, 1);
        tick();
        probe(1, 0);
        probe(0, 1);
    endtask

    initial begin
        rst = 1'b1;
        i_in_valid = 1'b0; i_in_data = '0;
        i_busy_1 = 1'b0; i_func_valid_1 = 1'b0; i_func_data_1 = '0;
        i_busy_2 = 1'b0; i_func_valid_2 = 1'b0; i_func_data_2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        probe(0, 1);
        probe(1, 0);

        // Words 10..13, busy low 4 cycles before rising, spurious layer-2 valid in FUNC1
        full_run(10, 4, 1'b1, 7, 8, 9, 8'h55, 8'hAA);

        // Abort during FUNC1 after two words
        load1(20);
        wait_busy(1, 0, 3);
        fword1(0, 1);
        fword1(1, 2);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        probe(0, 1);
        probe(1, 0);

        // Fresh run after the abort
        full_run(30, 0, 1'b0, 4, 5, 6, 8'h01, 8'hFE);

        fin_req = 1'b1;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/fc_chain_sched.md
Name: fc_chain_sched

Overview:
- Sequencer for a two-layer fully-connected chain built from two fc_layer instances.
- Streams host activations into layer 1's input buffer and starts layer 1.
- Triggers layer 1's activation function, then routes its output words into layer 2's input buffer.
- Starts layer 2, triggers its function, and streams the final results back to the host.

Parameters:
input_size_1, 784, layer-1 input vector length
output_size_1, 784, layer-1 output length; must equal input_size_2 (elaboration error otherwise)
input_size_2, 784, layer-2 input vector length
output_size_2, 1500, layer-2 output length
datatype_size, 8, activation word width
output_datatype_size, datatype_size, function-output word width; must equal datatype_size

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_in_valid  in  1  host input word valid
i_in_data  in  datatype_size  host input word
o_in_ready  out  1  scheduler accepts host word
o_out_valid  out  1  final result word valid (1-cycle strobe, no backpressure)
o_out_data  out  output_datatype_size  final result word
o_busy  out  1  inference in progress
o_done  out  1  1-cycle pulse with last result word
o_ibuf_we_1  out  1  layer-1 ibuf write enable
o_ibuf_wr_data_1  out  datatype_size  layer-1 ibuf data
o_ibuf_addr_1  out  $clog2(input_size_1)  layer-1 ibuf address
o_start_1  out  1  layer-1 MVM start pulse
i_busy_1  in  1  layer-1 controller busy
o_func_start_1  out  1  layer-1 function start pulse
i_func_valid_1  in  1  layer-1 function output valid
i_func_data_1  in  output_datatype_size  layer-1 function output
o_ibuf_we_2, o_ibuf_wr_data_2, o_ibuf_addr_2 ($clog2(input_size_2)), o_start_2, i_busy_2, o_func_start_2, i_func_valid_2, i_func_data_2: same as layer-1 set, for layer 2

Behaviour:
- All outputs are registered. On rst: every output is 0, the word counter cnt is 0, state is LOAD1. Assertion mid-operation aborts immediately with no partial completion.
- States: LOAD1, GAP1, START1, WAIT1, FUNC1, GAP2, START2, WAIT2, FUNC2.

State actions and transitions:
- LOAD1:
  - o_in_ready = 1.
  - An accept is i_in_valid & o_in_ready. Each accept drives o_ibuf_we_1 = 1, o_ibuf_addr_1 = cnt and o_ibuf_wr_data_1 = i_in_data on the next cycle; cnt then increments.
  - The accept with cnt == input_size_1-1 moves to GAP1 and clears cnt.
- GAP1: one cycle; the final ibuf write is on the bus. Move to START1.
- START1: o_start_1 = 1 for exactly one cycle, seen_busy is cleared, move to WAIT1. o_in_ready = 0 in every state except LOAD1.
- WAIT1:
  - i_busy_1 = 1 sets seen_busy.
  - seen_busy & !i_busy_1 moves to FUNC1, with o_func_start_1 = 1 for exactly one cycle on entry.
  - Busy must be observed high at least once before its fall counts; a low busy before the first high is ignored.
- FUNC1:
  - Each i_func_valid_1 produces a registered write into ibuf 2 on the next cycle: o_ibuf_we_2 = 1, o_ibuf_addr_2 = cnt, o_ibuf_wr_data_2 = i_func_data_1; cnt increments.
  - The word with cnt == output_size_1-1 moves to GAP2 and clears cnt.
- GAP2, START2, WAIT2: identical to GAP1, START1, WAIT1, using the layer-2 ports.
- FUNC2:
  - Each i_func_valid_2 gives o_out_valid = 1 and o_out_data = i_func_data_2 on the next cycle.
  - The word with cnt == output_size_2-1 moves to LOAD1, clears cnt, and asserts o_done in the same cycle as that last o_out_valid.

Other rules:
- i_func_valid_x outside FUNCx is ignored: no write, no count.
- o_busy = 1 whenever state != LOAD1 or cnt != 0. A new inference may begin loading in the cycle after o_done.
- Counters saturate nowhere; they wrap only by explicit clear at a terminal count.
- Throughput: one word per cycle in LOAD1, FUNC1 and FUNC2.

Test Plan:
1. Params 4/3/3/2, rst held 3 cycles → all outputs 0, o_in_ready = 1 after release.
2. Host streams words 10, 11, 12, 13 back-to-back → ibuf_1 writes addr 0..3 with data 10..13. o_start_1 pulses exactly 2 cycles after the last accept; o_in_ready drops to 0 the cycle after the last accept.
3. i_busy_1 high 5 cycles then low → o_func_start_1 single pulse 1 cycle after the fall. Layer-1 func words 7, 8, 9 with gaps → ibuf_2 addr 0..2, data 7..9, then o_start_2 pulse.
4. Layer-2 busy cycle, then func words 0x55, 0xAA → o_out_valid twice with 0x55, 0xAA. o_done coincides with 0xAA; o_busy = 0 the next cycle.
5. In WAIT1, i_busy_1 is held low 4 cycles before rising → no func start until after the subsequent fall. A spurious i_func_valid_2 during FUNC1 → no output, count unchanged.
6. rst asserted during FUNC1 after 2 words → all outputs 0 immediately. A fresh 4-word load then completes a full run correctly.
